// File: rtl/unidade_entrada_saida_pkg.sv
// Shared types for the I/O unit: FSM state encoding and default word width.
package unidade_entrada_saida_pkg;

    localparam int DATA_W_PADRAO = 32;

    // 2'd3 is unused; the FSM default branch steers it back to IDLE.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ESPERA = 2'd1,
        PRONTO = 2'd2
    } estado_t;

endpackage

// File: rtl/unidade_entrada_saida_if.sv
// Bus between the control unit/datapath/board and the I/O unit.
interface unidade_entrada_saida_if #(
    parameter int DATA_W = 32,
    parameter int SW_W   = 16
);
    // WAIT handshake: the processor holds ler_da_entrada while stall is high;
    // the WAIT retires on the single cycle stall drops after a press (PRONTO),
    // and the processor must deassert ler_da_entrada by the next edge.
    logic              ler_da_entrada;
    logic              confirma_entrada;
    logic              print;
    logic [SW_W-1:0]   chaves;
    logic              botao;
    logic [DATA_W-1:0] dado_saida;
    logic              stall;
    logic              aguardando;
    logic [DATA_W-1:0] dado_entrada;
    logic              entrada_pendente;
    logic [DATA_W-1:0] display;
    logic              saida_valida;

    modport master (
        output ler_da_entrada, confirma_entrada, print, chaves, botao, dado_saida,
        input  stall, aguardando, dado_entrada, entrada_pendente, display, saida_valida
    );

    modport slave (
        input  ler_da_entrada, confirma_entrada, print, chaves, botao, dado_saida,
        output stall, aguardando, dado_entrada, entrada_pendente, display, saida_valida
    );
endinterface

// File: rtl/unidade_entrada_saida_filtro_botao.sv
// Confirm-button conditioning: 2-flop synchronizer, debouncer and a
// registered one-cycle pulse on each accepted press.
module unidade_entrada_saida_filtro_botao #(
    parameter int DEBOUNCE_CYCLES   = 500000,
    parameter bit BOTAO_ATIVO_BAIXO = 1'b1
) (
    input  logic clock,
    input  logic reset,
    input  logic botao,
    output logic pressao
);
    localparam int   CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic SOLTO = BOTAO_ATIVO_BAIXO ? 1'b1 : 1'b0;

    logic             sinc_1, sinc_2;
    logic             nivel;
    logic             estavel;
    logic [CNT_W-1:0] contador;
    logic             diferente;
    logic             aceita;

    assign nivel     = BOTAO_ATIVO_BAIXO ? ~sinc_2 : sinc_2;
    assign diferente = (nivel != estavel);
    assign aceita    = diferente && (contador == CNT_W'(DEBOUNCE_CYCLES - 1));

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sinc_1 <= SOLTO;
            sinc_2 <= SOLTO;
        end else begin
            sinc_1 <= botao;
            sinc_2 <= sinc_1;
        end
    end

    // Any cycle of agreement restarts the count, so bounce never accumulates.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            estavel  <= 1'b0;
            contador <= '0;
            pressao  <= 1'b0;
        end else begin
            pressao <= aceita && nivel;
            if (aceita) begin
                estavel  <= nivel;
                contador <= '0;
            end else if (diferente) begin
                contador <= contador + 1'b1;
            end else begin
                contador <= '0;
            end
        end
    end
endmodule

// File: rtl/unidade_entrada_saida.sv
// Peripheral responder to WAIT / INPUT / OUTPUT: stalls the PC until a
// confirmed press, buffers the switches and drives the display register.
module unidade_entrada_saida
    import unidade_entrada_saida_pkg::*;
#(
    parameter int DATA_W            = DATA_W_PADRAO,
    parameter int SW_W              = 16,
    parameter int DEBOUNCE_CYCLES   = 500000,
    parameter bit BOTAO_ATIVO_BAIXO = 1'b1
) (
    input  logic                     clock,
    input  logic                     reset,
    unidade_entrada_saida_if.slave   bus,
    output estado_t                  estado_dbg
);
    estado_t           estado, proximo;
    logic              pressao;
    logic [DATA_W-1:0] buffer;
    logic              pendente;
    logic [DATA_W-1:0] display_q;
    logic              valida_q;

    unidade_entrada_saida_filtro_botao #(
        .DEBOUNCE_CYCLES  (DEBOUNCE_CYCLES),
        .BOTAO_ATIVO_BAIXO(BOTAO_ATIVO_BAIXO)
    ) u_filtro (
        .clock  (clock),
        .reset  (reset),
        .botao  (bus.botao),
        .pressao(pressao)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) estado <= IDLE;
        else        estado <= proximo;
    end

    // Presses outside ESPERA are dropped; a WAIT always needs a fresh press.
    always_comb begin
        proximo = estado;
        case (estado)
            IDLE:    if (bus.ler_da_entrada) proximo = ESPERA;
            ESPERA:  if (pressao) proximo = PRONTO;
            PRONTO:  proximo = IDLE;
            default: proximo = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            buffer   <= '0;
            pendente <= 1'b0;
        end else begin
            if (bus.confirma_entrada) pendente <= 1'b0;
            if (estado == ESPERA && pressao) begin
                buffer   <= DATA_W'(bus.chaves);
                pendente <= 1'b1;
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            display_q <= '0;
            valida_q  <= 1'b0;
        end else begin
            valida_q <= bus.print;
            if (bus.print) display_q <= bus.dado_saida;
        end
    end

    assign bus.stall            = (estado == ESPERA);
    assign bus.aguardando       = (estado == ESPERA);
    assign bus.dado_entrada     = buffer;
    assign bus.entrada_pendente = pendente;
    assign bus.display          = display_q;
    assign bus.saida_valida     = valida_q;
    assign estado_dbg           = estado;
endmodule

// File: tb/tb_unidade_entrada_saida.sv
// Directed bench for unidade_entrada_saida with a 4-cycle debounce.
module tb_unidade_entrada_saida;
    import unidade_entrada_saida_pkg::*;

    localparam int DATA_W = 32;
    localparam int SW_W   = 16;

    logic    clock;
    logic    reset;
    estado_t estado_dbg;
    int      compared;
    int      mismatched;

    unidade_entrada_saida_if #(.DATA_W(DATA_W), .SW_W(SW_W)) bus ();

    unidade_entrada_saida #(
        .DATA_W           (DATA_W),
        .SW_W             (SW_W),
        .DEBOUNCE_CYCLES  (4),
        .BOTAO_ATIVO_BAIXO(1'b1)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .bus       (bus),
        .estado_dbg(estado_dbg)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic check(input string tag, input logic [DATA_W-1:0] obs, input logic [DATA_W-1:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // From ESPERA with the button released and settled: press and hold.
    // Sync takes 2 edges, debounce 4 more, FSM leaves ESPERA on the 7th.
    task automatic aperta(input string tag, input logic [SW_W-1:0] valor);
        bus.chaves = valor;
        bus.botao  = 1'b0;
        ticks(6);
        check({tag, "_stall_antes"}, DATA_W'(bus.stall), 32'd1);
        tick();
        check({tag, "_stall_pronto"}, DATA_W'(bus.stall), 32'd0);
        check({tag, "_estado_pronto"}, DATA_W'(estado_dbg), DATA_W'(PRONTO));
        check({tag, "_dado"}, bus.dado_entrada, {16'h0, valor});
        check({tag, "_pendente"}, DATA_W'(bus.entrada_pendente), 32'd1);
    endtask

    initial begin
        compared   = 0;
        mismatched = 0;
        reset                = 1'b0;
        bus.ler_da_entrada   = 1'b0;
        bus.confirma_entrada = 1'b0;
        bus.print            = 1'b0;
        bus.chaves           = '0;
        bus.botao            = 1'b1;
        bus.dado_saida       = '0;
        ticks(2);
        reset = 1'b1;
        tick();

        check("rst_stall", DATA_W'(bus.stall), 32'd0);
        check("rst_estado", DATA_W'(estado_dbg), DATA_W'(IDLE));
        check("rst_dado", bus.dado_entrada, 32'd0);
        check("rst_display", bus.display, 32'd0);

        // INPUT with no prior WAIT returns the reset buffer.
        bus.confirma_entrada = 1'b1;
        tick();
        bus.confirma_entrada = 1'b0;
        check("input_sem_wait", bus.dado_entrada, 32'd0);

        // WAIT then press.
        bus.ler_da_entrada = 1'b1;
        tick();
        check("wait_stall", DATA_W'(bus.stall), 32'd1);
        check("wait_aguardando", DATA_W'(bus.aguardando), 32'd1);
        aperta("t2", 16'h00A5);
        bus.ler_da_entrada = 1'b0;
        tick();
        check("t2_idle_stall", DATA_W'(bus.stall), 32'd0);
        check("t2_idle_estado", DATA_W'(estado_dbg), DATA_W'(IDLE));
        ticks(2);
        bus.botao = 1'b1;
        ticks(8);
        bus.confirma_entrada = 1'b1;
        tick();
        bus.confirma_entrada = 1'b0;
        check("t2_consumido", DATA_W'(bus.entrada_pendente), 32'd0);
        check("t2_buffer_retido", bus.dado_entrada, 32'h000000A5);

        // Bounce: level never holds 4 cycles.
        bus.ler_da_entrada = 1'b1;
        tick();
        for (int i = 0; i < 10; i++) begin
            bus.botao = ~bus.botao;
            ticks(2);
        end
        ticks(3);
        check("t3_stall", DATA_W'(bus.stall), 32'd1);
        check("t3_buffer", bus.dado_entrada, 32'h000000A5);
        check("t3_pendente", DATA_W'(bus.entrada_pendente), 32'd0);
        aperta("t3", 16'hBEEF);
        bus.ler_da_entrada = 1'b0;
        bus.botao = 1'b1;
        ticks(8);
        bus.confirma_entrada = 1'b1;
        tick();
        bus.confirma_entrada = 1'b0;

        // Press in IDLE, then WAIT with the button still held.
        bus.chaves = 16'h7777;
        bus.botao  = 1'b0;
        ticks(10);
        check("t4_idle_pendente", DATA_W'(bus.entrada_pendente), 32'd0);
        check("t4_idle_estado", DATA_W'(estado_dbg), DATA_W'(IDLE));
        bus.ler_da_entrada = 1'b1;
        ticks(12);
        check("t4_segurado_stall", DATA_W'(bus.stall), 32'd1);
        bus.botao = 1'b1;
        ticks(8);
        check("t4_solto_stall", DATA_W'(bus.stall), 32'd1);
        check("t4_buffer", bus.dado_entrada, 32'h0000BEEF);
        aperta("t4", 16'h1234);
        bus.ler_da_entrada = 1'b0;
        tick();
        bus.botao = 1'b1;
        ticks(8);

        // OUTPUT held three cycles.
        bus.print      = 1'b1;
        bus.dado_saida = 32'h12345678;
        tick();
        check("t5_disp0", bus.display, 32'h12345678);
        check("t5_val0", DATA_W'(bus.saida_valida), 32'd1);
        bus.dado_saida = 32'hDEADBEEF;
        tick();
        check("t5_disp1", bus.display, 32'hDEADBEEF);
        check("t5_val1", DATA_W'(bus.saida_valida), 32'd1);
        bus.dado_saida = 32'h0;
        tick();
        check("t5_disp2", bus.display, 32'h0);
        check("t5_val2", DATA_W'(bus.saida_valida), 32'd1);
        bus.print      = 1'b0;
        bus.dado_saida = 32'hFFFFFFFF;
        tick();
        check("t5_val_fim", DATA_W'(bus.saida_valida), 32'd0);
        check("t5_disp_fim", bus.display, 32'h0);

        // OUTPUT alongside INPUT and a WAIT, then back-to-back WAIT.
        bus.print            = 1'b1;
        bus.dado_saida       = 32'hCAFEF00D;
        bus.confirma_entrada = 1'b1;
        bus.ler_da_entrada   = 1'b1;
        tick();
        bus.print            = 1'b0;
        bus.confirma_entrada = 1'b0;
        check("t5_simult_disp", bus.display, 32'hCAFEF00D);
        check("t5_simult_pendente", DATA_W'(bus.entrada_pendente), 32'd0);
        check("t5_simult_stall", DATA_W'(bus.stall), 32'd1);
        aperta("t5b", 16'h5A5A);
        tick();
        check("b2b_idle_stall", DATA_W'(bus.stall), 32'd0);
        tick();
        check("b2b_espera_stall", DATA_W'(bus.stall), 32'd1);
        ticks(8);
        check("b2b_segurado_stall", DATA_W'(bus.stall), 32'd1);

        // Asynchronous reset mid-wait with outputs nonzero.
        #3;
        reset = 1'b0;
        #1;
        check("t6_stall", DATA_W'(bus.stall), 32'd0);
        check("t6_aguardando", DATA_W'(bus.aguardando), 32'd0);
        check("t6_estado", DATA_W'(estado_dbg), DATA_W'(IDLE));
        check("t6_dado", bus.dado_entrada, 32'd0);
        check("t6_pendente", DATA_W'(bus.entrada_pendente), 32'd0);
        check("t6_display", bus.display, 32'd0);
        check("t6_valida", DATA_W'(bus.saida_valida), 32'd0);
        bus.ler_da_entrada = 1'b0;
        bus.botao          = 1'b1;
        #2;
        reset = 1'b1;
        ticks(4);
        bus.chaves = 16'h9999;
        bus.botao  = 1'b0;
        ticks(10);
        check("t6_press_ignorado_pend", DATA_W'(bus.entrada_pendente), 32'd0);
        check("t6_press_ignorado_stall", DATA_W'(bus.stall), 32'd0);
        check("t6_press_ignorado_dado", bus.dado_entrada, 32'd0);
        bus.botao = 1'b1;
        ticks(8);
        bus.ler_da_entrada = 1'b1;
        tick();
        check("t6_novo_wait", DATA_W'(bus.stall), 32'd1);
        aperta("t6", 16'h0F0F);
        bus.ler_da_entrada = 1'b0;
        tick();
        check("t6_fim_estado", DATA_W'(estado_dbg), DATA_W'(IDLE));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
